// File: rtl/hex_dec_display.sv
// Byte display driver: hex or leading-zero-suppressed decimal on a 4-digit
// multiplexed common-anode seven-segment display, fed by a double-dabble converter.
module hex_dec_display #(
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_in,
    input  logic       dec_mode,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  src_q, src_d;
    logic [7:0]  cap_q, cap_d;
    logic [11:0] work_q, work_d;
    logic [2:0]  iter_q, iter_d;
    logic [7:0]  shown_q, shown_d;
    logic [11:0] bcd_q, bcd_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic [11:0] adj;
    logic [3:0]  nib;
    logic        blank;

    function automatic logic [3:0] fix3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // src shifts away during conversion, so cap holds the byte to commit
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cap_d   = cap_q;
        work_d  = work_q;
        iter_d  = iter_q;
        shown_d = shown_q;
        bcd_d   = bcd_q;
        adj     = {fix3(work_q[11:8]), fix3(work_q[7:4]), fix3(work_q[3:0])};
        case (state_q)
            S_IDLE: begin
                if (d_in != shown_q) begin
                    src_d   = d_in;
                    cap_d   = d_in;
                    work_d  = '0;
                    iter_d  = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                {work_d, src_d} = {adj, src_q} << 1;
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) state_d = S_DONE;
            end
            S_DONE: begin
                shown_d = cap_q;
                bcd_d   = work_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d = div_q + 16'd1;
        idx_d = idx_q;
        if (div_q == 16'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_comb begin
        nib   = '0;
        blank = 1'b1;
        case (idx_q)
            2'd2: begin
                nib   = bcd_q[11:8];
                blank = !dec_mode || (bcd_q[11:8] == 4'd0);
            end
            2'd1: begin
                nib   = dec_mode ? bcd_q[7:4] : shown_q[7:4];
                blank = dec_mode && (bcd_q[11:4] == 8'd0);
            end
            2'd0: begin
                nib   = dec_mode ? bcd_q[3:0] : shown_q[3:0];
                blank = 1'b0;
            end
            default: begin
                nib   = '0;
                blank = 1'b1;
            end
        endcase
        seg_d = blank ? 7'h7F : glyph(nib);
        an_d  = ~(4'b0001 << idx_q);
        dp_d  = !(!dec_mode && (idx_q == 2'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            cap_q   <= '0;
            work_q  <= '0;
            iter_q  <= '0;
            shown_q <= '0;
            bcd_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cap_q   <= cap_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            shown_q <= shown_d;
            bcd_q   <= bcd_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_hex_dec_display.sv
// Directed bench for hex_dec_display with SCAN_DIV=4: reset, hex/decimal content,
// leading-zero suppression, conversion latency, mid-conversion change, scan, reset abort.
module tb_hex_dec_display;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GC = 7'b1000110;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] GB = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic       dec_mode = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    hex_dec_display #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .dec_mode(dec_mode),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_digit(input int idx, output logic [6:0] s, output logic p);
        logic [3:0] want;
        bit found;
        want  = ~(4'b0001 << idx);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === want) found = 1;
        end
        if (!found) chk("scan_timeout", {8'h0, an}, {8'h0, want});
        s = seg;
        p = dp;
    endtask

    task automatic check_disp(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0, input logic [3:0] edp);
        logic [6:0] e [4];
        logic [6:0] s;
        logic p;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 3; i >= 0; i--) begin
            read_digit(i, s, p);
            chk($sformatf("%s_seg%0d", tag, i), {5'h0, s}, {5'h0, e[i]});
            chk($sformatf("%s_dp%0d", tag, i), {11'h0, p}, {11'h0, edp[i]});
        end
    endtask

    initial begin
        logic [6:0] es;
        logic [3:0] ea;
        int unsigned hits;
        bit found;

        // asynchronous reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_an", {8'h0, an}, 12'hF);
        chk("rst_seg", {5'h0, seg}, {5'h0, GB});
        chk("rst_dp", {11'h0, dp}, 12'h1);
        chk("rst_busy", {11'h0, busy}, 12'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_an", {8'h0, an}, 12'hE);
        chk("first_seg", {5'h0, seg}, {5'h0, G0});
        chk("first_dp", {11'h0, dp}, 12'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_busy", {11'h0, busy}, 12'h0);
        end

        // 0xA5 hex, then decimal without reconversion
        d_in = 8'hA5;
        repeat (14) @(negedge clk);
        check_disp("hexA5", GB, GB, GA, G5, 4'b1110);
        dec_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mode_busy", {11'h0, busy}, 12'h0);
        end
        check_disp("decA5", GB, G1, G6, G5, 4'b1111);

        // leading zeros
        d_in = 8'h07;
        repeat (14) @(negedge clk);
        check_disp("dec07", GB, GB, GB, G7, 4'b1111);
        d_in = 8'h00;
        repeat (14) @(negedge clk);
        check_disp("dec00", GB, GB, GB, G0, 4'b1111);
        d_in = 8'hFF;
        repeat (14) @(negedge clk);
        check_disp("decFF", GB, G2, G5, G5, 4'b1111);
        dec_mode = 1'b0;
        repeat (2) @(negedge clk);
        check_disp("hexFF", GB, GB, GF, GF, 4'b1110);

        // latency 0x00 -> 0x3C in hex mode; k counts negedges after E0
        d_in = 8'h00;
        repeat (14) @(negedge clk);
        d_in = 8'h3C;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("lat_busy_k%0d", k), {11'h0, busy}, {11'h0, (k <= 8)});
            if (an == 4'b1110)      es = (k >= 10) ? GC : G0;
            else if (an == 4'b1101) es = (k >= 10) ? G3 : G0;
            else                    es = GB;
            chk($sformatf("lat_seg_k%0d", k), {5'h0, seg}, {5'h0, es});
        end
        dec_mode = 1'b1;
        repeat (2) @(negedge clk);
        check_disp("dec3C", GB, GB, G6, G0, 4'b1111);
        dec_mode = 1'b0;
        repeat (2) @(negedge clk);

        // mid-conversion change 0x12 -> 0x34 before E3
        d_in = 8'h12;
        hits = 0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 2) d_in = 8'h34;
            if (k == 9)  chk("mid_gap_busy", {11'h0, busy}, 12'h0);
            if (k == 10) chk("mid_restart_busy", {11'h0, busy}, 12'h1);
            if (k == 19) chk("mid_end_busy", {11'h0, busy}, 12'h0);
            if (k >= 10 && k <= 19) begin
                if ((an == 4'b1110 && seg == G2) || (an == 4'b1101 && seg == G1)) hits++;
            end
        end
        chk("mid_seen12", {11'h0, (hits > 0)}, 12'h1);
        check_disp("hex34", GB, GB, G3, G4, 4'b1110);
        dec_mode = 1'b1;
        repeat (2) @(negedge clk);
        check_disp("dec34", GB, GB, G5, G2, 4'b1111);
        dec_mode = 1'b0;

        // scan rotation: align to the first cycle of digit 0
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === 4'b1101) found = 1;
        end
        if (!found) chk("scan_sync1", {8'h0, an}, 12'hD);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an === 4'b1110) found = 1;
        end
        if (!found) chk("scan_sync0", {8'h0, an}, 12'hE);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            ea = ~(4'b0001 << ((k / 4) % 4));
            chk($sformatf("scan_k%0d", k), {8'h0, an}, {8'h0, ea});
        end

        // reset abort during conversion
        @(negedge clk);
        d_in = 8'h99;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_pre", {11'h0, busy}, 12'h1);
        #2 rst = 1'b1;
        #1;
        chk("abort_an", {8'h0, an}, 12'hF);
        chk("abort_seg", {5'h0, seg}, {5'h0, GB});
        chk("abort_dp", {11'h0, dp}, 12'h1);
        chk("abort_busy", {11'h0, busy}, 12'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_rel_an", {8'h0, an}, 12'hE);
        chk("abort_rel_seg", {5'h0, seg}, {5'h0, G0});
        chk("abort_rel_busy", {11'h0, busy}, 12'h1);
        repeat (14) @(negedge clk);
        check_disp("hex99", GB, GB, G9, G9, 4'b1110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
